// File: rtl/vcve2_vec_sequencer.sv
// Vector ALU sequencer: walks a register group one 32-bit word at a time through
// read vs2 / read vs1 / read old vd / compute / write, against a single-port VRF.
package vcve2_vec_pkg;
    typedef enum logic {VALU_MOVE = 1'b0, VALU_ADD = 1'b1} valu_op_e;
    typedef enum logic [1:0] {VOP_A_VREG_A = 2'd0, VOP_A_REG_A = 2'd1, VOP_A_IMM = 2'd2} vop_a_sel_e;
    typedef enum logic [2:0] {VSEW_8 = 3'd0, VSEW_16 = 3'd1, VSEW_32 = 3'd2, VSEW_64 = 3'd3} vsew_e;
    typedef enum logic [2:0] {
        LMUL_1 = 3'd0, LMUL_2 = 3'd1, LMUL_4 = 3'd2, LMUL_8 = 3'd3,
        LMUL_RSVD = 3'd4, LMUL_F8 = 3'd5, LMUL_F4 = 3'd6, LMUL_F2 = 3'd7
    } vlmul_e;
    typedef enum logic [2:0] {VRF_IDLE, VRF_READ1, VRF_READ2, VRF_READ3, V_OP, VRF_WRITE} vrf_state_t;
endpackage

module vcve2_vec_sequencer
    import vcve2_vec_pkg::*;
#(
    parameter int unsigned VLEN = 128,
    parameter int unsigned AW   = 5 + $clog2(VLEN / 32)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  valu_op_e                 op_i,
    input  vop_a_sel_e               opa_sel_i,
    input  logic [4:0]               vs1_i,
    input  logic [4:0]               vs2_i,
    input  logic [4:0]               vd_i,
    input  logic [31:0]              scalar_i,
    input  vsew_e                    vsew_i,
    input  vlmul_e                   vlmul_i,
    input  logic [$clog2(VLEN):0]    vl_i,
    output logic                     vrf_req_o,
    output logic                     vrf_we_o,
    output logic [AW-1:0]            vrf_addr_o,
    output logic [31:0]              vrf_wdata_o,
    input  logic [31:0]              vrf_rdata_i,
    output logic                     done_o,
    output logic                     err_o
);
    localparam int VLW = $clog2(VLEN) + 1;
    localparam int CW  = VLW - 2;
    localparam int WSH = $clog2(VLEN / 32);

    typedef struct packed {
        logic          illegal;
        logic          empty;
        logic [CW-1:0] n_words;
        logic [1:0]    last_bytes;
    } cfg_t;

    // VLMAX is a power of two, so it is built from exponents; negative means below one element.
    function automatic cfg_t decode_cfg(vsew_e sew, vlmul_e lmul, logic [VLW-1:0] vl);
        cfg_t           cfg;
        int             lmul_exp;
        int             vlmax_exp;
        logic [VLW-1:0] vlmax;
        logic [VLW-1:0] vl_eff;
        logic [VLW-1:0] bytes;
        lmul_exp       = lmul[2] ? int'(lmul) - 8 : int'(lmul);
        vlmax_exp      = $clog2(VLEN) + lmul_exp - 3 - int'(sew);
        vlmax          = (vlmax_exp < 0) ? '0 : VLW'(1) << vlmax_exp;
        vl_eff         = (vl < vlmax) ? vl : vlmax;
        bytes          = vl_eff << sew[1:0];
        cfg.illegal    = (sew > VSEW_32) || (lmul == LMUL_RSVD);
        cfg.empty      = (vl_eff == '0);
        cfg.n_words    = bytes[VLW-1:2] + CW'(|bytes[1:0]);
        cfg.last_bytes = bytes[1:0];
        return cfg;
    endfunction

    function automatic logic [AW-1:0] word_addr(logic [4:0] vreg, logic [CW-1:0] k);
        return AW'(({27'd0, vreg} << WSH) + {{(32 - CW){1'b0}}, k});
    endfunction

    vrf_state_t  state_q;
    valu_op_e    op_q;
    vop_a_sel_e  opa_sel_q;
    vsew_e       vsew_q;
    logic [4:0]  vs1_q, vs2_q, vd_q;
    logic [31:0] scalar_q, vs2_data_q, vs1_data_q;
    logic [CW-1:0] n_words_q, word_q;
    logic [1:0]  last_bytes_q;

    cfg_t        req_cfg;
    logic        need_vs2, need_vs1, last_word, partial;
    logic [31:0] opa_rep, opa, sum, result, merged;

    assign req_cfg   = decode_cfg(vsew_i, vlmul_i, vl_i);
    assign need_vs2  = (op_q == VALU_ADD);
    assign need_vs1  = (opa_sel_q == VOP_A_VREG_A);
    assign last_word = (word_q == n_words_q - CW'(1));
    assign partial   = last_word && (last_bytes_q != 2'd0);
    assign ready_o   = (state_q == VRF_IDLE);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path infers a latch.
        opa_rep = scalar_q;
        sum     = '0;
        case (vsew_q)
            VSEW_8:  opa_rep = {4{scalar_q[7:0]}};
            VSEW_16: opa_rep = {2{scalar_q[15:0]}};
            default: opa_rep = scalar_q;
        endcase
        opa = need_vs1 ? vs1_data_q : opa_rep;
        case (vsew_q)
            VSEW_8:  for (int b = 0; b < 4; b++) sum[8*b +: 8] = vs2_data_q[8*b +: 8] + opa[8*b +: 8];
            VSEW_16: for (int h = 0; h < 2; h++) sum[16*h +: 16] = vs2_data_q[16*h +: 16] + opa[16*h +: 16];
            default: sum = vs2_data_q + opa;
        endcase
        result = (op_q == VALU_ADD) ? sum : opa;
        merged = result;
        for (int b = 0; b < 4; b++) begin
            if (partial && (2'(b) >= last_bytes_q)) merged[8*b +: 8] = vrf_rdata_i[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= VRF_IDLE;
            op_q         <= VALU_MOVE;
            opa_sel_q    <= VOP_A_VREG_A;
            vsew_q       <= VSEW_8;
            vs1_q        <= '0;
            vs2_q        <= '0;
            vd_q         <= '0;
            scalar_q     <= '0;
            n_words_q    <= '0;
            last_bytes_q <= '0;
            word_q       <= '0;
            vs2_data_q   <= '0;
            vs1_data_q   <= '0;
            vrf_req_o    <= 1'b0;
            vrf_we_o     <= 1'b0;
            vrf_addr_o   <= '0;
            vrf_wdata_o  <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments; the defaults make each strobe one cycle wide.
            vrf_req_o   <= 1'b0;
            vrf_we_o    <= 1'b0;
            vrf_addr_o  <= '0;
            vrf_wdata_o <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            case (state_q)
                VRF_IDLE: if (valid_i) begin
                    op_q         <= op_i;
                    opa_sel_q    <= opa_sel_i;
                    vsew_q       <= vsew_i;
                    vs1_q        <= vs1_i;
                    vs2_q        <= vs2_i;
                    vd_q         <= vd_i;
                    scalar_q     <= scalar_i;
                    n_words_q    <= req_cfg.n_words;
                    last_bytes_q <= req_cfg.last_bytes;
                    word_q       <= '0;
                    if (req_cfg.illegal) begin
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                    end else if (req_cfg.empty) begin
                        done_o <= 1'b1;
                    end else begin
                        state_q    <= VRF_READ1;
                        vrf_req_o  <= (op_i == VALU_ADD);
                        vrf_addr_o <= (op_i == VALU_ADD) ? word_addr(vs2_i, '0) : '0;
                    end
                end
                VRF_READ1: begin
                    state_q    <= VRF_READ2;
                    vrf_req_o  <= need_vs1;
                    vrf_addr_o <= need_vs1 ? word_addr(vs1_q, word_q) : '0;
                end
                VRF_READ2: begin
                    if (need_vs2) vs2_data_q <= vrf_rdata_i;
                    state_q    <= VRF_READ3;
                    vrf_req_o  <= partial;
                    vrf_addr_o <= partial ? word_addr(vd_q, word_q) : '0;
                end
                VRF_READ3: begin
                    if (need_vs1) vs1_data_q <= vrf_rdata_i;
                    state_q <= V_OP;
                end
                V_OP: begin
                    state_q     <= VRF_WRITE;
                    vrf_req_o   <= 1'b1;
                    vrf_we_o    <= 1'b1;
                    vrf_addr_o  <= word_addr(vd_q, word_q);
                    vrf_wdata_o <= merged;
                    done_o      <= last_word;
                end
                VRF_WRITE: begin
                    if (last_word) begin
                        state_q <= VRF_IDLE;
                    end else begin
                        word_q     <= word_q + CW'(1);
                        state_q    <= VRF_READ1;
                        vrf_req_o  <= need_vs2;
                        vrf_addr_o <= need_vs2 ? word_addr(vs2_q, word_q + CW'(1)) : '0;
                    end
                end
                default: state_q <= VRF_IDLE;
            endcase
        end
    end
endmodule
